// File: rtl/spin_readout.sv
// spin_readout: runs a coupled-oscillator Ising network for a programmed time,
// then compares each cell's phase against cell 0 over a sampling window and
// commits a per-spin result bit (1 = out of phase for the majority of samples).
// Ports:
//   clk, axi_rstn          - clock, asynchronous active-low reset
//   start, run_cycles      - run request and anneal duration (latched on start)
//   ising_rstn             - network enable (low holds programmed spins)
//   osc_in                 - asynchronous cell outputs, bit 0 is the phase reference
//   busy, done             - activity flag, one-cycle completion pulse
//   rd_req, rd_addr        - register read strobe and select
//   rdata, rvalid          - read data, valid one cycle after rd_req
//   abort                  - only when SPIN_READOUT_ABORT_EN is defined
// Optional feature macro: SPIN_READOUT_ABORT_EN
module spin_readout #(
  parameter int unsigned NUM_SPINS     = 32,
  parameter int unsigned SAMPLE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 axi_rstn,
  input  logic                 start,
  input  logic [31:0]          run_cycles,
  output logic                 ising_rstn,
  input  logic [NUM_SPINS-1:0] osc_in,
  output logic                 busy,
  output logic                 done,
  input  logic                 rd_req,
  input  logic [1:0]           rd_addr,
  output logic [31:0]          rdata,
  output logic                 rvalid
`ifdef SPIN_READOUT_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam int unsigned CW = $clog2(SAMPLE_CYCLES) + 1;
  localparam logic [CW-1:0] HALF = CW'(SAMPLE_CYCLES / 2);
  localparam logic [31:0] LAST_SAMPLE = 32'(SAMPLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [NUM_SPINS-1:0] osc_meta, osc_sync;
  logic [31:0]          cnt, run_latch, result, result_nxt;
  logic [CW-1:0]        mcnt [NUM_SPINS];
  logic                 done_flag, abort_flag, abort_hit, status_rd;
  logic                 busy_nxt, ising_nxt, done_nxt;

`ifdef SPIN_READOUT_ABORT_EN
  assign abort_hit = abort && ((state == RUN) || (state == SAMPLE));
`else
  assign abort_hit = 1'b0;
`endif

  assign status_rd = rd_req && (rd_addr == 2'd1);

  // Two-flop synchronizer on the asynchronous cell outputs
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      osc_meta <= '0;
      osc_sync <= '0;
    end else begin
      osc_meta <= osc_in;
      osc_sync <= osc_meta;
    end
  end

  // State register
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state logic; one down-counter serves both the anneal and the sample window
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (abort_hit) state_next = IDLE;
               else if (cnt == '0) state_next = SAMPLE;
      SAMPLE:  if (abort_hit) state_next = IDLE;
               else if (cnt == '0) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register
  always_comb begin
    busy_nxt  = (state_next != IDLE);
    ising_nxt = (state_next == RUN) || (state_next == SAMPLE);
    done_nxt  = (state_next == COMMIT);
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      busy       <= 1'b0;
      ising_rstn <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      ising_rstn <= ising_nxt;
      done       <= done_nxt;
    end
  end

  // Majority vote: strictly more than half the samples out of phase; bit 0 is the reference
  always_comb begin
    result_nxt = '0;
    for (int i = 1; i < NUM_SPINS; i++) result_nxt[i] = (mcnt[i] > HALF);
  end

  // Counters and result register
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cnt       <= '0;
      run_latch <= '0;
      result    <= '0;
      for (int i = 0; i < NUM_SPINS; i++) mcnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= run_cycles;
            run_latch <= run_cycles;
          end
        end
        RUN: begin
          if (abort_hit)       cnt <= '0;
          else if (cnt == '0)  cnt <= LAST_SAMPLE;
          else                 cnt <= cnt - 32'd1;
        end
        SAMPLE: begin
          if (abort_hit) begin
            cnt <= '0;
            for (int i = 0; i < NUM_SPINS; i++) mcnt[i] <= '0;
          end else begin
            if (cnt != '0) cnt <= cnt - 32'd1;
            for (int i = 0; i < NUM_SPINS; i++)
              mcnt[i] <= mcnt[i] + CW'(osc_sync[i] ^ osc_sync[0]);
          end
        end
        COMMIT: begin
          result <= result_nxt;
          for (int i = 0; i < NUM_SPINS; i++) mcnt[i] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a status read wins
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      done_flag  <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      if (state == COMMIT) done_flag <= 1'b1;
      else if (status_rd)  done_flag <= 1'b0;
      if (abort_hit)       abort_flag <= 1'b1;
      else if (status_rd)  abort_flag <= 1'b0;
    end
  end

  // Register read port, one cycle latency
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= rd_req;
      if (rd_req) begin
        case (rd_addr)
          2'd0:    rdata <= result;
          2'd1:    rdata <= {29'b0, abort_flag, done_flag, busy};
          2'd2:    rdata <= run_latch;
          default: rdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spin_readout.sv
module tb_spin_readout;

  logic        clk = 1'b0;
  logic        axi_rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] run_cycles = '0;
  logic        ising_rstn;
  logic [3:0]  osc_in = 4'b0000;
  logic        busy, done;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_addr = 2'd0;
  logic [31:0] rdata;
  logic        rvalid;
`ifdef SPIN_READOUT_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  spin_readout #(.NUM_SPINS(4), .SAMPLE_CYCLES(64)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .start(start), .run_cycles(run_cycles),
    .ising_rstn(ising_rstn), .osc_in(osc_in), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rdata(rdata), .rvalid(rvalid)
`ifdef SPIN_READOUT_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic v);
    @(negedge clk); rd_req = 1'b1; rd_addr = a;
    @(negedge clk); rd_req = 1'b0; d = rdata; v = rvalid;
  endtask

  // Starts a run; after 'hold' sampled edges osc_in returns to all-in-phase (0 = never).
  // A second start is pulsed at negedge 'restart' (0 = never).
  task automatic do_run(input logic [31:0] rc, input logic [3:0] pat, input int hold,
                        input int restart, output int hi, output int dn, output bit to);
    int after;
    hi = 0; dn = 0; to = 1'b1; after = -1;
    @(negedge clk); start = 1'b1; run_cycles = rc; osc_in = pat;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = (k + 1 == restart);
      if (k + 1 == hold) osc_in = 4'b0000;
      if (ising_rstn) hi++;
      if (done) begin dn++; if (after < 0) after = 0; end
      if (after >= 0) begin
        after++;
        if (after == 4) begin to = 1'b0; break; end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    #12;
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (ising_rstn !== 1'b0) begin n_bad++; $display("FAIL reset_ising got %b want 0", ising_rstn); end
    n_cmp++; if (rvalid !== 1'b0)     begin n_bad++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    n_cmp++; if (rdata !== 32'h0)     begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    @(negedge clk); axi_rstn = 1'b1;
    rd(2'd1, d, v);
    n_cmp++; if (d !== 32'h0 || v !== 1'b1) begin n_bad++; $display("FAIL reset_status got %h/%b want 0/1", d, v); end
    rd(2'd0, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", d); end
  endtask

  task automatic test_basic();
    int hi, dn; bit to; logic [31:0] d; logic v;
    do_run(32'd10, 4'b0000, 0, 0, hi, dn, to);
    n_cmp++; if (to)       begin n_bad++; $display("FAIL basic_timeout got timeout want done"); end
    n_cmp++; if (hi != 75) begin n_bad++; $display("FAIL basic_ising_high got %0d want 75", hi); end
    n_cmp++; if (dn != 1)  begin n_bad++; $display("FAIL basic_done_pulses got %0d want 1", dn); end
    rd(2'd0, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL basic_result got %h want 0", d); end
    rd(2'd2, d, v);
    n_cmp++; if (d !== 32'd10) begin n_bad++; $display("FAIL basic_run_latch got %h want a", d); end
    rd(2'd3, d, v);
    n_cmp++; if (d !== 32'h0 || v !== 1'b1) begin n_bad++; $display("FAIL basic_addr3 got %h/%b want 0/1", d, v); end
    @(negedge clk);
    n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL basic_rvalid_idle got %b want 0", rvalid); end
  endtask

  task automatic test_patterns();
    logic [3:0]  pats [3] = '{4'b0100, 4'b1011, 4'b1010};
    logic [31:0] exps [3] = '{32'h4, 32'h4, 32'hA};
    int hi, dn; bit to; logic [31:0] d; logic v;
    for (int p = 0; p < 3; p++) begin
      do_run(32'd3, pats[p], 0, 0, hi, dn, to);
      rd(2'd0, d, v);
      n_cmp++; if (to || d !== exps[p]) begin n_bad++; $display("FAIL pattern_%0d got %h want %h", p, d, exps[p]); end
    end
    osc_in = 4'b0000;
  endtask

  task automatic test_threshold();
    int hi, dn; bit to; logic [31:0] d; logic v;
    do_run(32'd0, 4'b0010, 32, 0, hi, dn, to);
    rd(2'd0, d, v);
    n_cmp++; if (to || d !== 32'h0) begin n_bad++; $display("FAIL tie_32of64 got %h want 0", d); end
    do_run(32'd0, 4'b0010, 33, 0, hi, dn, to);
    rd(2'd0, d, v);
    n_cmp++; if (to || d !== 32'h2) begin n_bad++; $display("FAIL over_33of64 got %h want 2", d); end
  endtask

  task automatic test_busy_read();
    logic [31:0] d; logic v; bit seen;
    @(negedge clk); start = 1'b1; run_cycles = 32'd5; osc_in = 4'b0000;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rd(2'd0, d, v);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL busy_old_result got %h want 2", d); end
    rd(2'd1, d, v);
    n_cmp++; if (d[0] !== 1'b1) begin n_bad++; $display("FAIL busy_status_bit got %b want 1", d[0]); end
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin @(negedge clk); if (done) seen = 1'b1; end
    repeat (2) @(negedge clk);
    rd(2'd0, d, v);
    n_cmp++; if (!seen || d !== 32'h0) begin n_bad++; $display("FAIL busy_new_result got %h/%b want 0/1", d, seen); end
  endtask

  task automatic test_back_to_back();
    int hi, dn; bit to; logic [31:0] d; logic v;
    do_run(32'd0, 4'b0000, 0, 5, hi, dn, to);
    n_cmp++; if (to || dn != 1) begin n_bad++; $display("FAIL b2b_done_pulses got %0d want 1", dn); end
    n_cmp++; if (hi != 65)      begin n_bad++; $display("FAIL b2b_ising_high got %0d want 65", hi); end
    rd(2'd1, d, v);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL b2b_status1 got %h want 2", d); end
    rd(2'd1, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL b2b_status2 got %h want 0", d); end
  endtask

  task automatic test_reset_mid_sample();
    int hi, dn; bit to; logic [31:0] d; logic v; int ndone;
    @(negedge clk); start = 1'b1; run_cycles = 32'd0; osc_in = 4'b0010;
    @(negedge clk); start = 1'b0;
    repeat (22) @(negedge clk);
    rd_req = 1'b1; rd_addr = 2'd1;
    @(posedge clk); #2; axi_rstn = 1'b0; rd_req = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_cmp++; if (ising_rstn !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ising got %b want 0", ising_rstn); end
    n_cmp++; if (rvalid !== 1'b0)     begin n_bad++; $display("FAIL mid_rst_rvalid got %b want 0", rvalid); end
    n_cmp++; if (rdata !== 32'h0)     begin n_bad++; $display("FAIL mid_rst_rdata got %h want 0", rdata); end
    @(negedge clk); axi_rstn = 1'b1; osc_in = 4'b0000;
    ndone = 0;
    repeat (6) begin @(negedge clk); if (done) ndone++; end
    n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL mid_rst_done got %0d want 0", ndone); end
    do_run(32'd0, 4'b0010, 20, 0, hi, dn, to);
    rd(2'd0, d, v);
    n_cmp++; if (to || d !== 32'h0) begin n_bad++; $display("FAIL mid_rst_fresh got %h want 0", d); end
  endtask

`ifdef SPIN_READOUT_ABORT_EN
  task automatic test_abort();
    int hi, dn; bit to; logic [31:0] d; logic v; int ndone;
    do_run(32'd0, 4'b0100, 0, 0, hi, dn, to);
    rd(2'd1, d, v);
    @(negedge clk); start = 1'b1; run_cycles = 32'd50; osc_in = 4'b0000;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || ising_rstn !== 1'b0) begin n_bad++; $display("FAIL abort_idle got %b%b want 00", busy, ising_rstn); end
    ndone = 0;
    repeat (80) begin @(negedge clk); if (done) ndone++; end
    n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL abort_done got %0d want 0", ndone); end
    rd(2'd1, d, v);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL abort_status got %h want 4", d); end
    rd(2'd1, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL abort_status_clr got %h want 0", d); end
    rd(2'd0, d, v);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL abort_result_kept got %h want 4", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_threshold();
    test_busy_read();
    test_back_to_back();
    test_reset_mid_sample();
`ifdef SPIN_READOUT_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
